// File: rtl/arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding and
// write-counter width.
package arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int CNT_W = 8;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr,
// searching upward and wrapping NREQ-1 -> 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any
);
  logic [PW:0] idx;

  // Descending scan so the smallest offset from ptr is the last (winning) assignment.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (req[idx[PW-1:0]]) winner = idx[PW-1:0];
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning a shared register; one write per grant, one idle
// cycle between grants. Optional grant hold selected by `ARB_LOCK_EN.
module shared_reg_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  valid,
  output logic [CNT_W-1:0]      wr_count
);
  localparam int PW = $clog2(NREQ);

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, gidx, gidx_n, win, wsel;
  logic [NREQ-1:0] gnt_n;
  logic            any, we;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .any    (any)
  );

`ifndef ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_n = IDLE;
    gnt_n   = '0;
    ptr_n   = ptr;
    gidx_n  = gidx;
    we      = 1'b0;
    wsel    = gidx;
    case (state)
      IDLE: if (any) begin
        gnt_n[win] = 1'b1;
        we         = 1'b1;
        wsel       = win;
        gidx_n     = win;
        ptr_n      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        state_n    = GRANT;
      end
      GRANT: begin
`ifdef ARB_LOCK_EN
        if (req[gidx] & lock[gidx]) begin
          gnt_n   = gnt;
          state_n = LOCKED;
        end
`endif
      end
`ifdef ARB_LOCK_EN
      // Owner keeps writing every cycle it holds req & lock; ptr stays put.
      LOCKED: if (req[gidx] & lock[gidx]) begin
        gnt_n   = gnt;
        we      = 1'b1;
        state_n = LOCKED;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      gidx     <= '0;
      valid    <= 1'b0;
      wr_count <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
      if (we) begin
        valid    <= 1'b1;
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (we) q <= wdata[int'(wsel)*WIDTH +: WIDTH];
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench: behavioural model compared every cycle, plus directed
// literal expectations and randomized traffic with occasional resets.
module tb_shared_reg_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req, lock;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    q;
  logic            valid;
  logic [7:0]      wr_count;

  int checks = 0, failures = 0;
  bit cmp_en = 0;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .lock(lock),
    .gnt(gnt), .q(q), .valid(valid), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = just granted, 2 = held.
  int mphase, mowner, mptr, mcnt;
  logic [NREQ-1:0] mgnt;
  logic [W-1:0] mq;
  bit mvalid;

  always @(posedge clk) begin
    if (!reset) begin
      mphase = 0; mptr = 0; mcnt = 0; mgnt = '0; mq = '0; mvalid = 0; mowner = 0;
    end else if (mphase == 0) begin
      int found;
      found = -1;
      for (int k = 0; k < NREQ; k++)
        if (found < 0 && req[(mptr + k) % NREQ]) found = (mptr + k) % NREQ;
      if (found >= 0) begin
        mowner = found;
        mgnt   = '0; mgnt[found] = 1'b1;
        mq     = wdata[found*W +: W];
        mptr   = (found + 1) % NREQ;
        mcnt   = (mcnt + 1) % 256;
        mvalid = 1;
        mphase = 1;
      end else mgnt = '0;
    end else begin
`ifdef ARB_LOCK_EN
      if (req[mowner] && lock[mowner]) begin
        if (mphase == 2) begin
          mq   = wdata[mowner*W +: W];
          mcnt = (mcnt + 1) % 256;
        end
        mphase = 2;
      end else begin
        mgnt = '0; mphase = 0;
      end
`else
      mgnt = '0; mphase = 0;
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("model_gnt", 32'(gnt), 32'(mgnt));
      chk("model_q", 32'(q), 32'(mq));
      chk("model_valid", 32'(valid), 32'(mvalid));
      chk("model_wr_count", 32'(wr_count), 32'(mcnt));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk_all(input string nm, input logic [NREQ-1:0] eg, input logic [W-1:0] eq,
                         input bit ev, input int ec);
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_q"}, 32'(q), 32'(eq));
    chk({nm, "_valid"}, 32'(valid), 32'(ev));
    chk({nm, "_cnt"}, 32'(wr_count), ec);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; lock = '0; tick(); reset = 1'b1;
  endtask

  logic [NREQ-1:0] seq_g [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001};
  logic [W-1:0]    seq_q [9] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd1};

  initial begin
    reset = 1'b0; req = 4'b1111; lock = '0; wdata = '0;
    tick();
    cmp_en = 1;
    // Reset held with everyone requesting.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("reset_hold", 4'b0000, 8'h00, 0, 0);
    end

    // Single request, then the mandatory idle cycle.
    reset = 1'b1; req = 4'b0100; wdata = '0; wdata[2*W +: W] = 8'hA5;
    tick(); chk_all("single", 4'b0100, 8'hA5, 1, 1);
    req = '0;
    tick(); chk_all("single_drop", 4'b0000, 8'hA5, 1, 1);

    // Everyone requesting continuously: round robin with idle gaps.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) wdata[i*W +: W] = W'(i + 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(seq_g[i]));
      chk("rr_q", 32'(q), 32'(seq_q[i]));
    end

    // Pointer wrap after granting requester 3.
    do_reset();
    req = 4'b1000; tick(); chk("wrap_g3", 32'(gnt), 32'b1000);
    req = 4'b1001; tick(); chk("wrap_gap", 32'(gnt), 32'b0000);
    tick(); chk("wrap_g0", 32'(gnt), 32'b0001);

`ifdef ARB_LOCK_EN
    do_reset();
    req = 4'b0010; lock = 4'b0010; wdata[1*W +: W] = 8'h10;
    tick(); chk_all("lock_grant", 4'b0010, 8'h10, 1, 1);
    tick(); chk_all("lock_enter", 4'b0010, 8'h10, 1, 1);
    for (int i = 0; i < 4; i++) begin
      wdata[1*W +: W] = W'(8'h20 + 8'h10 * i);
      tick(); chk_all("lock_hold", 4'b0010, W'(8'h20 + 8'h10 * i), 1, 2 + i);
    end
    lock = '0;
    tick(); chk_all("lock_drop", 4'b0000, 8'h50, 1, 5);
    // Reset while locked.
    lock = 4'b0010; tick(); tick();
    reset = 1'b0; tick(); chk_all("reset_locked", 4'b0000, 8'h00, 0, 0);
    reset = 1'b1;
`endif

    // Reset in the GRANT cycle.
    do_reset();
    req = 4'b0001; wdata[0 +: W] = 8'h3C;
    tick(); chk("pre_rst_gnt", 32'(gnt), 32'b0001);
    reset = 1'b0;
    tick(); chk_all("reset_grant", 4'b0000, 8'h00, 0, 0);
    reset = 1'b1;

    // 256 writes wrap the counter.
    req = 4'b0001;
    for (int i = 1; i <= 511; i++) begin
      tick();
      if (i == 509) chk("cnt_255", 32'(wr_count), 255);
    end
    chk("cnt_wrap", 32'(wr_count), 0);
    chk("cnt_wrap_valid", 32'(valid), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 63) != 0);
      req   = NREQ'($urandom);
      lock  = NREQ'($urandom);
      wdata = ($urandom_range(0, 3) == 0) ? wdata : (NREQ*W)'($urandom);
      tick();
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter NREQ SHALL default to 4 and set the number of requesters (2..8).
REQ-002 Parameter WIDTH SHALL default to 8 and set the shared register width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
REQ-005 req  input  NREQ  SHALL carry the per-requester write request, level, active-high.
REQ-006 wdata  input  NREQ*WIDTH  SHALL carry the per-requester write data; requester i SHALL use bits [i*WIDTH +: WIDTH].
REQ-007 lock  input  NREQ  SHALL carry the per-requester grant-hold request (used only with ARB_LOCK_EN).
REQ-008 gnt  output  NREQ  SHALL be the registered one-hot (or zero) grant.
REQ-009 q  output  WIDTH  SHALL be the shared register contents.
REQ-010 valid  output  1  SHALL be high once q has been written at least once since reset.
REQ-011 wr_count  output  8  SHALL count completed writes to q.

Function
REQ-012 FSM states SHALL be IDLE, GRANT, LOCKED.
REQ-013 IDLE with req != 0: winner = first asserted req at or after ptr, searching upward with wrap NREQ-1 -> 0; next edge: gnt <= onehot(winner), q <= wdata[winner], state <= GRANT.
REQ-014 IDLE with req == 0: gnt SHALL be 0; q, ptr, and wr_count SHALL hold.
REQ-015 On each grant, ptr SHALL become (winner+1) mod NREQ; wrap from NREQ-1 SHALL give 0.
REQ-016 GRANT SHALL last exactly one cycle: next edge gnt <= 0, state <= IDLE (no write), giving one idle cycle between grants so requesters can drop req.
REQ-017 Grant latency SHALL be one cycle: req sampled at edge N produces gnt and an updated q visible after edge N.
REQ-018 Simultaneous requests SHALL be served in round-robin order; with all NREQ requesting continuously, each SHALL be granted once per 2*NREQ cycles.
REQ-019 wr_count SHALL increment by 1 on every edge that writes q and SHALL wrap 255 -> 0.
REQ-020 valid SHALL set on the first write and stay set until reset.
REQ-021 Requests dropped before being sampled SHALL be lost; no request queuing.

Reset
REQ-022 reset == 0 at a rising edge SHALL force state = IDLE, gnt = 0, q = 0, ptr = 0, valid = 0, wr_count = 0, overriding any state, including GRANT and LOCKED mid-operation.
REQ-023 The first grant SHALL be possible at the first edge after reset returns to 1.

Configuration
REQ-024 Macro ARB_LOCK_EN SHALL select the lock feature.
REQ-025 With ARB_LOCK_EN: in GRANT, if req[w] & lock[w] for granted w, the next state SHALL be LOCKED with gnt held.
REQ-026 In LOCKED, each edge with req[w] & lock[w] SHALL write q <= wdata[w], increment wr_count, and hold gnt; otherwise gnt <= 0 and state <= IDLE with no write; ptr SHALL be unchanged while LOCKED.
REQ-027 Without ARB_LOCK_EN: lock SHALL be ignored, LOCKED SHALL be unreachable, and behaviour SHALL be exactly REQ-013..REQ-021.

Structure
REQ-028 A shared package arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, GRANT=2'd1, LOCKED=2'd2) and the wr_count width constant (8).
REQ-029 Round-robin winner selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs winner index, any).
REQ-030 The shared register q SHALL be a plain synchronous-reset DFF bank with an enable.

Verification
REQ-031 Hold reset=0 for 5 edges with req=4'b1111 -> gnt=0, q=0, valid=0, wr_count=0 throughout.
REQ-032 Single request: req=4'b0100, wdata[2]=8'hA5 -> next edge gnt=4'b0100, q=8'hA5, valid=1, wr_count=1; the following edge gnt=0.
REQ-033 All request continuously with wdata[i]=i+1 -> gnt sequence 0001,0,0010,0,0100,0,1000,0,0001 and q follows 1,2,3,4,1.
REQ-034 Grant to requester 3, then req=4'b1001 -> next grant goes to requester 0 (ptr wrap).
REQ-035 ARB_LOCK_EN: requester 1 holds req&lock for 4 cycles with changing wdata -> gnt=0010 held, q tracks each wdata, wr_count +4; when lock drops, gnt=0 next edge.
REQ-036 reset=0 asserted during GRANT or LOCKED -> next edge all outputs at reset values; 256 writes -> wr_count wraps to 0.
